// File: rtl/demux_1xn_stream_pkg.sv
// demux_pkg: shared constants and helpers for the 1-to-N stream demux.
//   DEF_DATA_W / DEF_NUM_CH : default payload width and channel count
//   DROP_CNT_W              : width of the optional drop counter
//   clog2 / sel_w           : select-index width derivation
package demux_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DROP_CNT_W = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // A select index is always at least one bit wide, even for tiny channel counts.
    function automatic int sel_w(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

endpackage

// File: rtl/demux_1xn_stream_if.sv
// demux_1xn_stream_if: upstream handshake plus per-channel downstream bus.
//   in_valid/in_data/in_sel/in_bcast : upstream word, destination, broadcast flag
//   out_rdy                          : upstream ready
//   out_valid/out_data/in_ready      : per-channel stream, data flattened
//   out_err                          : out-of-range select pulse
// slave is the demux side, master is the upstream/downstream environment.
interface demux_1xn_stream_if
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
);
    localparam int SEL_W = sel_w(NUM_CH);

    logic                     in_valid;
    logic                     out_rdy;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_err;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, in_ready,
        output out_rdy, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, in_ready,
        input  out_rdy, out_valid, out_data, out_err
    );

endinterface

// File: rtl/demux_ch_buf.sv
// demux_ch_buf: one-deep output buffer for a single demux channel.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i/data_i: write a new word (wins over a simultaneous drain)
//   ready_i      : downstream ready
//   valid_o/data_o: buffered word
//   free_o       : buffer can take a word this cycle (empty or draining)
module demux_ch_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              free_o
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            // Load during a drain keeps valid high: back-to-back words, no bubble.
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: routes one upstream stream to NUM_CH one-deep channel
// buffers, by index or broadcast to all.
//   in_clk, in_rst : clock, synchronous active-high reset
//   bus (slave)    : upstream handshake, per-channel outputs, out_err pulse
//   out_drop_cnt   : saturating count of out-of-range words (only when
//                    DEMUX_STATS_EN is defined)
// Outputs depend on in_valid/in_data only through registers; out_rdy is a
// function of select, broadcast, channel state and in_ready.
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    demux_1xn_stream_if.slave     bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0] out_drop_cnt
`endif
);
    localparam int SEL_W  = sel_w(NUM_CH);
    localparam int SEL_CH = 1 << SEL_W;

    logic [NUM_CH-1:0] ch_free;
    logic [SEL_CH-1:0] ch_free_pad;
    logic [NUM_CH-1:0] load;
    logic              sel_ok;
    logic              accept;
    logic              err_q, err_d;

    // Unused select codes read as free so they never stall; those words are dropped.
    generate
        if (SEL_CH > NUM_CH) begin : g_pad
            assign ch_free_pad = {{(SEL_CH-NUM_CH){1'b1}}, ch_free};
        end else begin : g_nopad
            assign ch_free_pad = ch_free;
        end
    endgenerate

    assign sel_ok = ({1'b0, bus.in_sel} < (SEL_W+1)'(NUM_CH));

    always_comb begin
        bus.out_rdy = 1'b0;
        if (!in_rst) begin
            // Broadcast waits for every channel so it is all-or-nothing.
            if (bus.in_bcast) bus.out_rdy = &ch_free;
            else              bus.out_rdy = ch_free_pad[bus.in_sel];
        end
    end

    assign accept = bus.in_valid && bus.out_rdy;
    assign err_d  = accept && !bus.in_bcast && !sel_ok;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign load[i] = accept && (bus.in_bcast || (sel_ok && bus.in_sel == SEL_W'(i)));

            demux_ch_buf #(.DATA_W(DATA_W)) u_buf (
                .clk_i   (in_clk),
                .rst_i   (in_rst),
                .load_i  (load[i]),
                .data_i  (bus.in_data),
                .ready_i (bus.in_ready[i]),
                .valid_o (bus.out_valid[i]),
                .data_o  (bus.out_data[i*DATA_W +: DATA_W]),
                .free_o  (ch_free[i])
            );
        end
    endgenerate

    always_ff @(posedge in_clk) begin
        if (in_rst) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.out_err = err_q;

`ifdef DEMUX_STATS_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (err_d && drop_q != '1) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign out_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// tb_demux_1xn_stream: directed bench for the stream demux.
// A 4-channel instance is tracked by a per-channel expected-word scoreboard
// filled by the stimulus and drained by a negedge monitor; a 3-channel
// instance exercises the out-of-range select path.
module tb_demux_1xn_stream;
    import demux_pkg::*;

    logic in_clk;
    logic in_rst;
    int   total;
    int   bad;

    demux_1xn_stream_if #(.DATA_W(8), .NUM_CH(4)) b4 ();
    demux_1xn_stream_if #(.DATA_W(8), .NUM_CH(3)) b3 ();

`ifdef DEMUX_STATS_EN
    logic [7:0] drop4, drop3;
`endif

    demux_1xn_stream #(.DATA_W(8), .NUM_CH(4)) dut4 (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .bus          (b4.slave)
`ifdef DEMUX_STATS_EN
        ,
        .out_drop_cnt (drop4)
`endif
    );

    demux_1xn_stream #(.DATA_W(8), .NUM_CH(3)) dut3 (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .bus          (b3.slave)
`ifdef DEMUX_STATS_EN
        ,
        .out_drop_cnt (drop3)
`endif
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    logic [7:0] expq [4][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge in_clk);
    endtask

    // Scoreboard monitor: every valid channel must show the oldest expected
    // word; a completed transfer retires it.
    always @(negedge in_clk) begin
        if (!in_rst) begin
            for (int i = 0; i < 4; i++) begin
                if (b4.out_valid[i] === 1'b1) begin
                    total++;
                    if (expq[i].size() == 0) begin
                        bad++;
                        $display("FAIL mon_ch%0d: got word %0h want none", i, b4.out_data[i*8 +: 8]);
                    end else begin
                        if (b4.out_data[i*8 +: 8] !== expq[i][0]) begin
                            bad++;
                            $display("FAIL mon_ch%0d: got %0h want %0h", i, b4.out_data[i*8 +: 8], expq[i][0]);
                        end
                        if (b4.in_ready[i]) void'(expq[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        in_rst = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_sel = '0; b4.in_bcast = 1'b0; b4.in_ready = '0;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_sel = '0; b3.in_bcast = 1'b0; b3.in_ready = 3'b111;
        repeat (2) @(posedge in_clk);
        mid();
        chk("rst_valid", b4.out_valid, 0);
        chk("rst_data", b4.out_data, 0);
        chk("rst_err", b4.out_err, 0);
        chk("rst_rdy", b4.out_rdy, 0);
        tick();
        in_rst = 1'b0;

        // Single word to channel 2, visible exactly one cycle later.
        b4.in_ready = 4'b1111; b4.in_valid = 1'b1; b4.in_sel = 2; b4.in_data = 8'hA5;
        expq[2].push_back(8'hA5);
        mid(); chk("t1_rdy", b4.out_rdy, 1); tick();
        b4.in_valid = 1'b0;
        mid(); chk("t1_vld", b4.out_valid, 4'b0100); chk("t1_data", b4.out_data[23:16], 8'hA5); tick();
        mid(); chk("t1_drained", b4.out_valid, 0); tick();

        // Stalled channel 1: backpressure, hold, then replace during drain.
        b4.in_ready = 4'b1101; b4.in_valid = 1'b1; b4.in_sel = 1; b4.in_data = 8'h11;
        expq[1].push_back(8'h11);
        mid(); chk("t2_rdy_empty", b4.out_rdy, 1); tick();
        b4.in_data = 8'h22;
        mid(); chk("t2_rdy_full", b4.out_rdy, 0); tick();
        mid(); chk("t2_hold", b4.out_data[15:8], 8'h11); tick();
        b4.in_ready = 4'b1111;
        expq[1].push_back(8'h22);
        mid(); chk("t2_rdy_drain", b4.out_rdy, 1); tick();
        b4.in_valid = 1'b0;
        mid(); chk("t2_vld", b4.out_valid, 4'b0010); chk("t2_data", b4.out_data[15:8], 8'h22); tick();
        mid(); chk("t2_empty", b4.out_valid, 0); tick();

        // Broadcast to all, then a blocked broadcast with channel 3 stalled.
        b4.in_bcast = 1'b1; b4.in_valid = 1'b1; b4.in_data = 8'h3C;
        for (int i = 0; i < 4; i++) expq[i].push_back(8'h3C);
        mid(); chk("t3_rdy", b4.out_rdy, 1); tick();
        b4.in_valid = 1'b0; b4.in_ready = 4'b0111;
        mid(); chk("t3_vld", b4.out_valid, 4'b1111); chk("t3_data", b4.out_data, 32'h3C3C3C3C); tick();
        b4.in_valid = 1'b1; b4.in_data = 8'h5A;
        mid(); chk("t3_rdy_blocked", b4.out_rdy, 0); tick();
        b4.in_valid = 1'b0; b4.in_bcast = 1'b0;
        mid(); chk("t3_no_partial", b4.out_valid, 4'b1000); chk("t3_ch3", b4.out_data[31:24], 8'h3C); tick();
        b4.in_ready = 4'b1111;
        mid(); tick();
        mid(); chk("t3_empty", b4.out_valid, 0); tick();

        // Fill channels 0,1,3 then reset mid-operation.
        b4.in_ready = 4'b0000; b4.in_valid = 1'b1;
        b4.in_sel = 0; b4.in_data = 8'h01; expq[0].push_back(8'h01); tick();
        b4.in_sel = 1; b4.in_data = 8'h02; expq[1].push_back(8'h02); tick();
        b4.in_sel = 3; b4.in_data = 8'h04; expq[3].push_back(8'h04); tick();
        b4.in_valid = 1'b0;
        mid(); chk("t4_vld", b4.out_valid, 4'b1011); tick();
        in_rst = 1'b1; b4.in_valid = 1'b1; b4.in_sel = 2;
        mid(); chk("t4_rdy_in_rst", b4.out_rdy, 0); tick();
        b4.in_valid = 1'b0;
        mid();
        chk("t4_vld_rst", b4.out_valid, 0);
        chk("t4_data_rst", b4.out_data, 0);
        chk("t4_err_rst", b4.out_err, 0);
        for (int i = 0; i < 4; i++) expq[i].delete();
        tick();
        in_rst = 1'b0;

        // Three-channel instance: legal word, then out-of-range select.
        b3.in_valid = 1'b1; b3.in_sel = 2; b3.in_data = 8'h66;
        mid(); tick();
        b3.in_valid = 1'b0;
        mid(); chk("t5_vld", b3.out_valid, 3'b100); chk("t5_data", b3.out_data[23:16], 8'h66); tick();
        b3.in_valid = 1'b1; b3.in_sel = 3; b3.in_data = 8'h77;
        mid(); chk("t5_rdy_oor", b3.out_rdy, 1); tick();
        b3.in_valid = 1'b0;
        mid();
        chk("t5_err", b3.out_err, 1);
        chk("t5_vld_unch", b3.out_valid, 0);
`ifdef DEMUX_STATS_EN
        chk("t5_drop1", drop3, 1);
`endif
        tick();
        mid(); chk("t5_err_pulse", b3.out_err, 0); tick();

        // Long run of drops: counter saturates.
        b3.in_valid = 1'b1; b3.in_sel = 3;
        repeat (300) tick();
        b3.in_valid = 1'b0;
        mid();
        chk("t5_err_last", b3.out_err, 1);
`ifdef DEMUX_STATS_EN
        chk("t5_drop_sat", drop3, 255);
        chk("t5_drop4_zero", drop4, 0);
`endif
        tick();
        mid(); chk("t5_err_clr", b3.out_err, 0); chk("t5_vld_end", b3.out_valid, 0); tick();

        for (int i = 0; i < 4; i++) chk("sb_empty", expq[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1xn_stream.md
DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (1..64).
REQ-002 SHALL have parameter NUM_CH, default 4, output channel count (2..16, power of two not required).
REQ-003 SHALL derive localparam SEL_W = max(1, clog2(NUM_CH)); it is not overridable.
REQ-004 SHALL have port in_clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port in_rst, input, 1, reset, synchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, upstream word valid.
REQ-007 SHALL have port out_rdy, output, 1, upstream ready.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL have port in_sel, input, SEL_W, destination channel index.
REQ-010 SHALL have port in_bcast, input, 1, broadcast mode: deliver to all channels.
REQ-011 SHALL have port out_valid, output, NUM_CH, per-channel valid.
REQ-012 SHALL have port out_data, output, NUM_CH*DATA_W, flattened; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port in_ready, input, NUM_CH, per-channel downstream ready.
REQ-014 SHALL have port out_err, output, 1, one-cycle pulse on out-of-range select.

Function
REQ-015 SHALL hold a one-deep buffer per channel; ch_free[i] = !out_valid[i] || in_ready[i].
REQ-016 SHALL drive out_rdy combinationally: in_bcast ? AND of all ch_free : (in_sel < NUM_CH ? ch_free[in_sel] : 1).
REQ-017 SHALL accept a word when in_valid && out_rdy.
REQ-018 SHALL load the accepted word into the selected buffer, or every buffer when in_bcast=1.
REQ-019 SHALL present the word on out_data/out_valid of the target channel(s) exactly 1 cycle after acceptance.
REQ-020 SHALL clear out_valid[i] after a cycle with out_valid[i] && in_ready[i] and no new load to channel i.
REQ-021 SHALL keep out_valid[i]=1 and take the new data when drain and load coincide on channel i; no bubble.
REQ-022 SHALL hold out_data[i] stable while out_valid[i] && !in_ready[i].
REQ-023 SHALL accept a non-broadcast word with in_sel >= NUM_CH, discard it, and pulse out_err for 1 cycle.
REQ-024 SHALL leave buffers of channels not being loaded unaffected.
REQ-025 SHALL perform a broadcast only when all channels are free; a partial broadcast SHALL never occur.
REQ-026 SHALL NOT create a combinational path from in_valid or in_data to any output.

Reset
REQ-027 SHALL clear out_valid, out_data and out_err to 0 on an in_clk edge with in_rst=1.
REQ-028 SHALL discard buffered words on reset mid-operation; out_rdy is 0 while in_rst=1.

Configuration
REQ-029 SHALL, with DEMUX_STATS_EN defined, add output out_drop_cnt (8 bits), which counts discarded out-of-range words, saturates at 255, and clears on reset.
REQ-030 SHALL, without DEMUX_STATS_EN, have no out_drop_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-031 SHALL take shared constants from package demux_pkg: DATA_W/NUM_CH defaults, the clog2 function, and the drop-counter width (8).
REQ-032 SHALL instantiate sub-module demux_ch_buf, the per-channel one-deep buffer with load/drain, NUM_CH times via generate.

Verification (NUM_CH=4, DATA_W=8)
REQ-033 SHALL cover: in_sel=2, in_data=0xA5, in_valid=1, in_ready=4'b1111 -> next cycle out_valid=4'b0100, channel 2 data=0xA5.
REQ-034 SHALL cover: channel 1 full with in_ready[1]=0, then send to sel=1 -> out_rdy=0; set in_ready[1]=1 -> accepted and replaced in the same cycle, out_valid[1] stays 1.
REQ-035 SHALL cover: in_bcast=1, 0x3C, all channels free -> next cycle out_valid=4'b1111, all channels 0x3C; repeat with channel 3 stalled -> out_rdy=0 and nothing loaded.
REQ-036 SHALL cover: NUM_CH=3, in_sel=3 -> word accepted, out_err pulses once, out_valid unchanged; with DEMUX_STATS_EN, out_drop_cnt increments, and after 300 drops it reads 255.
REQ-037 SHALL cover: reset asserted with out_valid=4'b1011 -> after the edge, out_valid=0, out_data=0, out_err=0, out_rdy=0 during reset.
